// File: rtl/disaggregator_pkg.sv
// Shared constants and types for the wide-to-narrow
// disaggregator and its aggregator counterpart.
package disaggregator_pkg;

  localparam int DATA_WIDTH_DEF  = 11;
  localparam int FETCH_WIDTH_DEF = 6;

  function automatic int cnt_width(input int fw);
    return $clog2(fw + 1);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/disaggregator.sv
// Splits one wide word into a run of narrow elements,
// element 0 (LSB slice) first, with runtime fetch width.
module disaggregator
  import disaggregator_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
  parameter int CNT_WIDTH   = cnt_width(FETCH_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  input  logic                              change_fetch_width,
  input  logic [CNT_WIDTH-1:0]              input_fetch_width,
  output logic                              busy
);

  localparam int WW = FETCH_WIDTH * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] FW_MAX =
    CNT_WIDTH'(FETCH_WIDTH);

  logic [WW-1:0]        sr_q, sr_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [CNT_WIDTH-1:0] fw_r_q, fw_r_d;
  logic [CNT_WIDTH-1:0] fw_p_q, fw_p_d;
  logic                 pend_q, pend_d;
  state_e               state_q, state_d;

  logic [CNT_WIDTH-1:0] fw_eff;
  logic                 fw_ok;
  logic                 last;

  assign busy          = (state_q == EMIT);
  assign receiver_data = sr_q[DATA_WIDTH-1:0];
  assign receiver_enq  = busy & receiver_full_n;
  assign last          = (rem_q == CNT_WIDTH'(1));
  assign sender_deq    = sender_empty_n &
                         (~busy | (last & receiver_enq));
  assign fw_eff        = pend_q ? fw_p_q : fw_r_q;
  assign fw_ok         = change_fetch_width &
                         (input_fetch_width != '0) &
                         (input_fetch_width <= FW_MAX);

  // Next-state: load/shift, width handover, FSM view
  always_comb begin
    sr_d   = sr_q;
    rem_d  = rem_q;
    fw_r_d = fw_r_q;
    fw_p_d = fw_p_q;
    pend_d = pend_q;
    if (sender_deq) begin
      sr_d   = sender_data;
      rem_d  = fw_eff;
      fw_r_d = fw_eff;
      pend_d = 1'b0;
    end else if (receiver_enq) begin
      sr_d  = sr_q >> DATA_WIDTH;
      rem_d = rem_q - CNT_WIDTH'(1);
    end else if (!busy && pend_q) begin
      fw_r_d = fw_p_q;
      pend_d = 1'b0;
    end
    // A new request always targets the following word.
    if (fw_ok) begin
      fw_p_d = input_fetch_width;
      pend_d = 1'b1;
    end
    state_d = (rem_d != '0) ? EMIT : IDLE;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q    <= '0;
      rem_q   <= '0;
      fw_r_q  <= FW_MAX;
      fw_p_q  <= FW_MAX;
      pend_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      sr_q    <= sr_d;
      rem_q   <= rem_d;
      fw_r_q  <= fw_r_d;
      fw_p_q  <= fw_p_d;
      pend_q  <= pend_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_disaggregator.sv
// Randomized bench for disaggregator against an
// element-queue model of the upstream/downstream streams.
module tb_disaggregator;

  localparam int DW = 11;
  localparam int FW = 6;
  localparam int CW = 3;
  localparam int WW = DW * FW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [WW-1:0] sender_data = '0;
  logic          sender_empty_n = 1'b0;
  logic          sender_deq;
  logic [DW-1:0] receiver_data;
  logic          receiver_full_n = 1'b0;
  logic          receiver_enq;
  logic          change_fetch_width = 1'b0;
  logic [CW-1:0] input_fetch_width = '0;
  logic          busy;

  disaggregator dut (
    .clk                (clk),
    .rst                (rst),
    .sender_data        (sender_data),
    .sender_empty_n     (sender_empty_n),
    .sender_deq         (sender_deq),
    .receiver_data      (receiver_data),
    .receiver_full_n    (receiver_full_n),
    .receiver_enq       (receiver_enq),
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int deq_cnt = 0;

  logic [WW-1:0] up_q[$];
  int            elq[$];
  int            out_q[$];
  int            enq_cyc[$];
  int            deq_cyc[$];
  int            m_fw_r = FW;
  int            m_fw_p = FW;
  bit            m_pend = 0;

  bit            e_busy, e_enq, e_deq;
  int            fwe;
  logic [WW-1:0] w;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    elq.delete();
    m_fw_r = FW;
    m_fw_p = FW;
    m_pend = 0;
  endtask

  // Compare DUT against the model, then advance the model
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      e_busy = (elq.size() != 0);
      e_enq  = e_busy && receiver_full_n;
      e_deq  = sender_empty_n &&
               (elq.size() == 0 || (elq.size() == 1 && e_enq));
      chk("busy", busy, e_busy);
      chk("enq", receiver_enq, e_enq);
      chk("deq", sender_deq, e_deq);
      if (e_busy) chk("data", receiver_data, elq[0]);
      if (receiver_enq) begin
        out_q.push_back(receiver_data);
        enq_cyc.push_back(cyc);
      end
      if (sender_deq) begin
        deq_cnt++;
        deq_cyc.push_back(cyc);
      end
      if (e_enq) void'(elq.pop_front());
      if (e_deq) begin
        w = up_q.pop_front();
        fwe = m_pend ? m_fw_p : m_fw_r;
        for (int i = 0; i < fwe; i++)
          elq.push_back(int'(w[i*DW +: DW]));
        m_fw_r = fwe;
        m_pend = 0;
      end else if (!e_busy && m_pend) begin
        m_fw_r = m_fw_p;
        m_pend = 0;
      end
      if (change_fetch_width && input_fetch_width >= 1 &&
          input_fetch_width <= FW) begin
        m_fw_p = input_fetch_width;
        m_pend = 1;
      end
    end
    cyc++;
  end

  task automatic tick(input bit full, input bit chg,
                      input int fwin, input bit en);
    @(negedge clk);
    receiver_full_n    = full;
    change_fetch_width = chg;
    input_fetch_width  = CW'(fwin);
    sender_empty_n     = en && (up_q.size() != 0);
    sender_data        = (up_q.size() != 0) ? up_q[0] : '0;
  endtask

  function automatic logic [WW-1:0] rnd_word();
    logic [WW-1:0] r;
    for (int i = 0; i < FW; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((up_q.size() != 0 || elq.size() != 0) && n < bound) begin
      tick(1, 0, 0, 1);
      n++;
    end
    tick(1, 0, 0, 1);
    tick(1, 0, 0, 1);
    if (n >= bound) chk("drain_timeout", n, -1);
  endtask

  int d0;
  int n;

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_enq", receiver_enq, 0);
    chk("rst_deq", sender_deq, 0);
    chk("rst_data", receiver_data, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;

    // fw=2 word: 3, 1, then four 0x7FF upper slices
    tick(1, 1, 2, 0);
    tick(1, 0, 0, 0);
    w = {{4{11'h7FF}}, 11'd1, 11'd3};
    up_q.push_back(w);
    out_q.delete(); deq_cyc.delete(); enq_cyc.delete();
    d0 = deq_cnt;
    drain(20);
    tick(1, 0, 0, 0);
    chk("fw2_count", out_q.size(), 2);
    if (out_q.size() == 2) begin
      chk("fw2_e0", out_q[0], 3);
      chk("fw2_e1", out_q[1], 1);
      chk("fw2_lat", enq_cyc[0] - deq_cyc[0], 1);
    end
    chk("fw2_deqs", deq_cnt - d0, 1);
    chk("fw2_idle", busy, 0);

    // back-to-back full-width words, no bubbles
    tick(1, 1, 6, 0);
    tick(1, 0, 0, 0);
    repeat (3) up_q.push_back(rnd_word());
    out_q.delete(); enq_cyc.delete();
    d0 = deq_cnt;
    drain(40);
    chk("b2b_count", out_q.size(), 18);
    if (out_q.size() == 18)
      chk("b2b_gapless", enq_cyc[17] - enq_cyc[0], 17);
    chk("b2b_deqs", deq_cnt - d0, 3);

    // random downstream stalls
    repeat (4) up_q.push_back(rnd_word());
    out_q.delete();
    n = 0;
    while ((up_q.size() != 0 || elq.size() != 0) && n < 400) begin
      tick(1'($urandom_range(0, 1)), 0, 0, 1);
      n++;
    end
    drain(10);
    chk("stall_count", out_q.size(), 24);

    // mid-word change to 3: current word 6, next word 3
    up_q.push_back(rnd_word());
    up_q.push_back(rnd_word());
    out_q.delete();
    repeat (3) tick(1, 0, 0, 1);
    tick(1, 1, 3, 1);
    drain(40);
    chk("mid_change_count", out_q.size(), 9);

    // illegal widths ignored
    tick(1, 1, 6, 0);
    tick(1, 1, 0, 0);
    tick(1, 1, 7, 0);
    tick(1, 0, 0, 0);
    up_q.push_back(rnd_word());
    out_q.delete();
    drain(20);
    chk("illegal_fw_count", out_q.size(), 6);

    // reset after the second element of a word
    up_q.push_back(rnd_word());
    out_q.delete();
    n = 0;
    while (n < 20) begin
      tick(1, 0, 0, 1);
      #3;
      if (out_q.size() == 2) break;
      n++;
    end
    if (n >= 20) chk("pre_rst_timeout", n, -1);
    @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("mid_rst_enq", receiver_enq, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", receiver_data, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    repeat (3) tick(1, 0, 0, 1);
    chk("mid_rst_total", out_q.size(), 2);
    up_q.push_back(rnd_word());
    out_q.delete();
    drain(20);
    chk("post_rst_count", out_q.size(), 6);

    // fully random traffic and width changes
    for (int k = 0; k < 500; k++) begin
      if (up_q.size() < 3 && $urandom_range(0, 3) == 0)
        up_q.push_back(rnd_word());
      tick(1'($urandom_range(0, 3) != 0),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 7),
           1'($urandom_range(0, 4) != 0));
    end
    drain(200);
    chk("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
